// File: rtl/lfsr_period_ctrl_if.sv
// Signal bundle between lfsr_period_ctrl and its environment.
// The slave modport is the controller side; the master modport is the side that drives start and owns the LFSR.
interface lfsr_period_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] seed_in;
    logic [WIDTH-1:0] lfsr_q;
    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_seed;
    logic             lfsr_en;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   period;
    logic             maximal;
    logic             timeout;

    modport slave (
        input  start,
        input  seed_in,
        input  lfsr_q,
        output lfsr_load,
        output lfsr_seed,
        output lfsr_en,
        output busy,
        output done,
        output period,
        output maximal,
        output timeout
    );

    modport master (
        output start,
        output seed_in,
        output lfsr_q,
        input  lfsr_load,
        input  lfsr_seed,
        input  lfsr_en,
        input  busy,
        input  done,
        input  period,
        input  maximal,
        input  timeout
    );
endinterface

// File: rtl/lfsr_period_ctrl.sv
// Measures the number of steps an external LFSR needs to return to its seed.
// Define LFSR_CTRL_ZERO_GUARD_EN to capture an all-zero seed_in as 1.
module lfsr_period_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    lfsr_period_ctrl_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH:0] CNT_LIMIT = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0] CNT_MAX   = {1'b0, {WIDTH{1'b1}}};

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] seed_q,    seed_d;
    logic [WIDTH:0]   count_q,   count_d;
    logic [WIDTH:0]   period_q,  period_d;
    logic             maximal_q, maximal_d;
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] seed_cap;
    logic             match;
    logic             at_limit;
    logic             step_en;

    always_comb begin
`ifdef LFSR_CTRL_ZERO_GUARD_EN
        seed_cap = (bus.seed_in == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.seed_in;
`else
        seed_cap = bus.seed_in;
`endif
    end

    // count==0 excludes the seed itself, which is on lfsr_q right after the load.
    assign match    = (state_q == S_RUN) && (count_q != '0) && (bus.lfsr_q == seed_q);
    assign at_limit = (count_q == CNT_LIMIT);
    assign step_en  = (state_q == S_RUN) && !match && !at_limit;

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        count_d   = count_q;
        period_d  = period_q;
        maximal_d = maximal_q;
        timeout_d = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    seed_d  = seed_cap;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d   = '0;
                period_d  = '0;
                maximal_d = 1'b0;
                timeout_d = 1'b0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (step_en) begin
                    count_d = count_q + 1'b1;
                end
                if (match) begin
                    period_d  = count_q;
                    maximal_d = (count_q == CNT_MAX);
                    timeout_d = 1'b0;
                    state_d   = S_DONE;
                end else if (at_limit) begin
                    period_d  = CNT_LIMIT;
                    maximal_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            seed_q    <= '0;
            count_q   <= '0;
            period_q  <= '0;
            maximal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            count_q   <= count_d;
            period_q  <= period_d;
            maximal_q <= maximal_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.lfsr_load = (state_q == S_LOAD);
    assign bus.lfsr_seed = seed_q;
    assign bus.lfsr_en   = step_en;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.period    = period_q;
    assign bus.maximal   = maximal_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_lfsr_period_ctrl.sv
// Directed bench: a 16-bit controller on a maximal Galois LFSR and a 4-bit controller on selectable behavioural LFSR models.
module tb_lfsr_period_ctrl;

    logic clk = 1'b0;
    logic rst16;
    logic rst4;

    always #5 clk = ~clk;

    lfsr_period_ctrl_if #(.WIDTH(16)) b16 ();
    lfsr_period_ctrl_if #(.WIDTH(4))  b4 ();

    lfsr_period_ctrl #(.WIDTH(16)) u16 (.clk(clk), .reset(rst16), .bus(b16));
    lfsr_period_ctrl #(.WIDTH(4))  u4  (.clk(clk), .reset(rst4),  .bus(b4));

    // 16-bit Galois LFSR, polynomial mask 0xB400 (period 65535)
    always @(posedge clk) begin
        if (b16.lfsr_load)
            b16.lfsr_q <= b16.lfsr_seed;
        else if (b16.lfsr_en)
            b16.lfsr_q <= {1'b0, b16.lfsr_q[15:1]} ^ (b16.lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    // 4-bit models: 0 = mod-6 counter, 1 = saturating counter, 2 = Galois mask 0xC, 3 = stuck
    int unsigned mode4 = 0;

    function automatic logic [3:0] nxt4(input int unsigned m, input logic [3:0] q);
        case (m)
            0:       return (q >= 4'd5) ? 4'd0 : q + 4'd1;
            1:       return (q == 4'd15) ? 4'd15 : q + 4'd1;
            2:       return {1'b0, q[3:1]} ^ (q[0] ? 4'hC : 4'h0);
            default: return q;
        endcase
    endfunction

    always @(posedge clk) begin
        if (b4.lfsr_load)
            b4.lfsr_q <= b4.lfsr_seed;
        else if (b4.lfsr_en)
            b4.lfsr_q <= nxt4(mode4, b4.lfsr_q);
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        int unsigned mode;
        logic [3:0]  seed;
        logic [3:0]  exp_seed;
        int unsigned exp_period;
        logic        exp_max;
        logic        exp_to;
    } vec_t;

    vec_t vecs[10];

    task automatic measure4(input vec_t v);
        int unsigned n;
        bit got;
        @(negedge clk);
        mode4      = v.mode;
        b4.start   = 1'b1;
        b4.seed_in = v.seed;
        @(posedge clk);
        @(negedge clk);
        b4.start = 1'b0;
        chk("load4", 32'(b4.lfsr_load), 32'd1);
        chk("seed4", 32'(b4.lfsr_seed), 32'(v.exp_seed));
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (b4.done) got = 1'b1;
        end
        chk("latency4", n, v.exp_period + 2);
        chk("period4", 32'(b4.period), v.exp_period);
        chk("maximal4", 32'(b4.maximal), 32'(v.exp_max));
        chk("timeout4", 32'(b4.timeout), 32'(v.exp_to));
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse4", 32'({b4.done, b4.busy}), 32'd0);
        chk("period_hold4", 32'(b4.period), v.exp_period);
    endtask

    initial begin
        int unsigned n;
        bit got;
        int loads, dones, dbl, badp, bad_idle;
        bit prev_done;

        vecs[0] = '{0, 4'd2,  4'd2,  6,  1'b0, 1'b0};
        vecs[1] = '{0, 4'd0,  4'd0,  6,  1'b0, 1'b0};
        vecs[2] = '{0, 4'd9,  4'd9,  16, 1'b0, 1'b1};
        vecs[3] = '{1, 4'd0,  4'd0,  16, 1'b0, 1'b1};
        vecs[4] = '{1, 4'd14, 4'd14, 16, 1'b0, 1'b1};
        vecs[5] = '{1, 4'd15, 4'd15, 1,  1'b0, 1'b0};
        vecs[6] = '{2, 4'd1,  4'd1,  15, 1'b1, 1'b0};
        vecs[7] = '{2, 4'd8,  4'd8,  15, 1'b1, 1'b0};
        vecs[8] = '{3, 4'd5,  4'd5,  1,  1'b0, 1'b0};
`ifdef LFSR_CTRL_ZERO_GUARD_EN
        vecs[9] = '{2, 4'd0,  4'd1,  15, 1'b1, 1'b0};
`else
        vecs[9] = '{2, 4'd0,  4'd0,  1,  1'b0, 1'b0};
`endif

        rst16 = 1'b0;
        rst4  = 1'b0;
        b16.start = 1'b0;  b16.seed_in = '0;  b16.lfsr_q = '0;
        b4.start  = 1'b0;  b4.seed_in  = '0;  b4.lfsr_q  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset16", 32'({b16.busy, b16.done, b16.lfsr_load, b16.lfsr_en, b16.maximal, b16.timeout}), 32'd0);
        chk("reset16_period", 32'(b16.period), 32'd0);
        chk("reset4", 32'({b4.busy, b4.done, b4.lfsr_load, b4.lfsr_en, b4.maximal, b4.timeout, b4.lfsr_seed}), 32'd0);
        rst16 = 1'b1;
        rst4  = 1'b1;

        for (int i = 0; i < 10; i++) measure4(vecs[i]);

        // start held high: one LOAD and one done per 10-cycle measurement (period 6)
        @(negedge clk);
        mode4 = 0;
        b4.seed_in = 4'd2;
        b4.start = 1'b1;
        loads = 0; dones = 0; dbl = 0; badp = 0; prev_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (b4.lfsr_load) loads++;
            if (b4.done) begin
                dones++;
                if (prev_done) dbl++;
                if (b4.period !== 5'd6) badp++;
            end
            prev_done = b4.done;
        end
        b4.start = 1'b0;
        chk("b2b_loads", 32'(loads), 32'd4);
        chk("b2b_dones", 32'(dones), 32'd4);
        chk("b2b_double_done", 32'(dbl), 32'd0);
        chk("b2b_period", 32'(badp), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle", 32'(b4.busy), 32'd0);

        // 16-bit maximal run
        @(negedge clk);
`ifdef LFSR_CTRL_ZERO_GUARD_EN
        b16.seed_in = 16'h0000;
`else
        b16.seed_in = 16'h0001;
`endif
        b16.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b16.start = 1'b0;
        chk("load16", 32'(b16.lfsr_load), 32'd1);
        chk("seed16", 32'(b16.lfsr_seed), 32'h0001);
        n = 0;
        got = 1'b0;
        while (n < 70000 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (b16.done) got = 1'b1;
        end
        chk("latency16", n, 32'd65537);
        chk("period16", 32'(b16.period), 32'd65535);
        chk("maximal16", 32'(b16.maximal), 32'd1);
        chk("timeout16", 32'(b16.timeout), 32'd0);

`ifndef LFSR_CTRL_ZERO_GUARD_EN
        // all-zero seed sticks on an XOR LFSR
        @(negedge clk);
        b16.seed_in = 16'h0000;
        b16.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b16.start = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (b16.done) got = 1'b1;
        end
        chk("latency16_zero", n, 32'd3);
        chk("period16_zero", 32'(b16.period), 32'd1);
        chk("maximal16_zero", 32'(b16.maximal), 32'd0);
`endif

        // reset while RUN count is 100
        @(negedge clk);
        b16.seed_in = 16'h0001;
        b16.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b16.start = 1'b0;
        repeat (101) @(posedge clk);
        @(negedge clk);
        chk("run16_active", 32'({b16.busy, b16.lfsr_en}), 32'd3);
        rst16 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst16 = 1'b1;
        chk("midrst_busy", 32'(b16.busy), 32'd0);
        chk("midrst_en", 32'(b16.lfsr_en), 32'd0);
        chk("midrst_period", 32'(b16.period), 32'd0);
        chk("midrst_done", 32'(b16.done), 32'd0);
        chk("midrst_seed", 32'(b16.lfsr_seed), 32'd0);
        bad_idle = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (b16.busy || b16.done || b16.lfsr_en || b16.lfsr_load) bad_idle++;
        end
        chk("midrst_no_resume", 32'(bad_idle), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_period_ctrl.md
LFSR_PERIOD_CTRL -- requirements
Module: lfsr_period_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, meaning LFSR state width in bits (2..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request one period measurement, sampled only in IDLE.
REQ-005 SHALL have port: seed_in  input  WIDTH  starting seed, captured with start.
REQ-006 SHALL have port: lfsr_q  input  WIDTH  current state of the controlled LFSR.
REQ-007 SHALL have port: lfsr_load  output  1  load lfsr_seed into the LFSR at the next edge.
REQ-008 SHALL have port: lfsr_seed  output  WIDTH  seed value driven to the LFSR.
REQ-009 SHALL have port: lfsr_en  output  1  step the LFSR one state at the next edge.
REQ-010 SHALL have port: busy  output  1  high in LOAD, RUN and DONE.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when a measurement ends.
REQ-012 SHALL have port: period  output  WIDTH+1  measured steps to return to seed.
REQ-013 SHALL have port: maximal  output  1  period == 2^WIDTH-1.
REQ-014 SHALL have port: timeout  output  1  no return to seed within 2^WIDTH steps.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN, DONE; IDLE->LOAD on start; LOAD->RUN unconditionally; RUN->DONE on match or timeout; DONE->IDLE unconditionally.
REQ-016 SHALL, in IDLE with start=1, capture seed_in into an internal seed register.
REQ-017 SHALL, in LOAD, drive lfsr_load=1 and lfsr_seed=seed register for exactly one cycle, clear count, period, maximal and timeout.
REQ-018 SHALL drive lfsr_seed = seed register at all times; lfsr_load=0 outside LOAD.
REQ-019 SHALL keep a WIDTH+1-bit step counter, 0 on RUN entry, incremented in each RUN cycle where lfsr_en=1.
REQ-020 SHALL define match = (state==RUN) and (count!=0) and (lfsr_q==seed register).
REQ-021 SHALL drive lfsr_en = (state==RUN) and not match and (count != 2^WIDTH); lfsr_en=0 in all other states.
REQ-022 SHALL, on match, load period=count, maximal=(count==2^WIDTH-1), timeout=0, go to DONE.
REQ-023 SHALL, when count==2^WIDTH without match, load period=2^WIDTH, maximal=0, timeout=1, go to DONE; counter never wraps.
REQ-024 SHALL assert done only in DONE (one cycle); period/maximal/timeout SHALL hold until the next LOAD.
REQ-025 SHALL ignore start while busy=1; start held high continuously SHALL begin a new measurement on the cycle after DONE.
REQ-026 SHALL, with start sampled in cycle s and true period P, assert done in cycle s+P+3.
REQ-027 SHALL report period 1 for an LFSR stuck at its seed (e.g. all-zero XOR LFSR).

Reset
REQ-028 SHALL, when reset=0 at a rising edge, enter IDLE and clear seed register, count, period, maximal, timeout, done, lfsr_load, lfsr_en, busy to 0, regardless of current state.
REQ-029 SHALL, after reset mid-RUN, not resume; a new start is required.

Configuration
REQ-030 SHALL support macro LFSR_CTRL_ZERO_GUARD_EN: when defined, an all-zero seed_in SHALL be captured as value 1; when undefined, seed_in SHALL be captured unmodified, including all-zero.

Verification
REQ-031 SHALL verify: WIDTH=16 maximal XOR LFSR, seed 0x0001, start in cycle s -> done in cycle s+65538, period=65535, maximal=1, timeout=0.
REQ-032 SHALL verify: seed 0x0000, macro undefined -> period=1, maximal=0; macro defined -> period=65535, maximal=1, lfsr_seed=0x0001.
REQ-033 SHALL verify: start held high throughout -> back-to-back measurements, each with exactly one done pulse and no extra LOAD while busy.
REQ-034 SHALL verify: reset=0 at RUN count 100 -> next cycle IDLE, busy=0, lfsr_en=0, period=0, no done pulse.
REQ-035 SHALL verify: WIDTH=4 behavioral LFSR model with period 6 -> period=6, maximal=0; model that never revisits seed -> timeout=1, period=16.
